// File: rtl/i2c_arb_pkg.sv
// rtl/i2c_arb_pkg.sv - shared types and constants for the i2c bus arbiter
package i2c_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    XFER    = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  // 10 ms of byte watchdog at 32 MHz, and the bus-free gap between owners
  localparam int I2C_TIMEOUT_DEF = 320_000;
  localparam int I2C_GAP_DEF     = 32;

  // SSD1306-style control bytes carried in m_reg_addr
  localparam logic [7:0] OLED_CTRL_CMD = 8'h00;
  localparam logic [7:0] OLED_CTRL_DAT = 8'h40;

endpackage

// File: rtl/i2c_rr_pick.sv
// rtl/i2c_rr_pick.sv - combinational round-robin picker, first valid at or after rr_ptr
module i2c_rr_pick
  import i2c_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int PTR_W = 1
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] win,
  output logic             any
);

  logic [2*N_REQ-1:0] dbl_req;
  logic [2*N_REQ-1:0] dbl_shift;
  logic [N_REQ-1:0]   rot_req;
  logic [N_REQ-1:0]   rot_win;
  logic [2*N_REQ-1:0] dbl_back;

  // Rotate so rr_ptr sits at bit 0, isolate the lowest set bit, rotate back.
  assign dbl_req   = {req_valid, req_valid};
  assign dbl_shift = dbl_req >> rr_ptr;
  assign rot_req   = dbl_shift[N_REQ-1:0];
  assign rot_win   = rot_req & (~rot_req + N_REQ'(1));
  assign dbl_back  = {rot_win, rot_win} << rr_ptr;
  assign win       = dbl_back[2*N_REQ-1:N_REQ];
  assign any       = |req_valid;

endmodule

// File: rtl/i2c_bus_arbiter.sv
// rtl/i2c_bus_arbiter.sv - per-transaction round-robin owner of the i2c_master byte engine
module i2c_bus_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int TIMEOUT    = I2C_TIMEOUT_DEF,
  parameter int GAP_CYCLES = I2C_GAP_DEF
) (
  input  logic               clk_32M,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ-1:0]   req_last,
  input  logic [8*N_REQ-1:0] req_reg_addr,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ack,
  output logic [N_REQ-1:0]   req_err,
  output logic [N_REQ-1:0]   grant,
  output logic               m_enable,
  output logic [7:0]         m_reg_addr,
  output logic [7:0]         m_data_in,
  input  logic               m_done
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(N_REQ - 1);

  arb_state_e       state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] owner_q;
  logic             last_q;
  logic [WD_W-1:0]  wdog;
  logic [GAP_W-1:0] gap_cnt;

  logic [N_REQ-1:0] pick_win;
  logic             pick_any;
  logic [PTR_W-1:0] win_idx;
  logic [PTR_W-1:0] sel_idx;
  logic [PTR_W-1:0] next_ptr;
  logic [7:0]       addr_arr [N_REQ];
  logic [7:0]       data_arr [N_REQ];
  logic             sel_valid;
  logic             sel_last;
  logic [7:0]       sel_addr;
  logic [7:0]       sel_data;

  i2c_rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .win       (pick_win),
    .any       (pick_any)
  );

  for (genvar g = 0; g < N_REQ; g++) begin : g_slice
    assign addr_arr[g] = req_reg_addr[8*g +: 8];
    assign data_arr[g] = req_data[8*g +: 8];
  end

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_win[i]) win_idx = PTR_W'(i);
    end
  end

  // In IDLE the candidate is the picker's winner; afterwards only the owner is ever looked at.
  assign sel_idx   = (state == IDLE) ? win_idx : owner_q;
  assign sel_valid = req_valid[sel_idx];
  assign sel_last  = req_last[sel_idx];
  assign sel_addr  = addr_arr[sel_idx];
  assign sel_data  = data_arr[sel_idx];
  assign next_ptr  = (owner_q == PTR_MAX) ? '0 : owner_q + PTR_W'(1);

  always_ff @(posedge clk_32M or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= '0;
      m_enable   <= 1'b0;
      m_reg_addr <= 8'h00;
      m_data_in  <= 8'h00;
      req_ack    <= '0;
      req_err    <= '0;
      rr_ptr     <= '0;
      owner_q    <= '0;
      last_q     <= 1'b0;
      wdog       <= '0;
      gap_cnt    <= '0;
    end else begin
      req_ack <= '0;
      req_err <= '0;
      case (state)
        IDLE: begin
          gap_cnt <= '0;
          if (pick_any) begin
            grant      <= pick_win;
            owner_q    <= win_idx;
            m_reg_addr <= sel_addr;
            m_data_in  <= sel_data;
            last_q     <= sel_last;
            m_enable   <= 1'b1;
            req_ack    <= pick_win;
            wdog       <= '0;
            state      <= XFER;
          end
        end
        XFER: begin
          // A completing byte beats a watchdog expiry in the same cycle.
          if (m_done) begin
            if (!last_q && sel_valid) begin
              m_data_in <= sel_data;
              last_q    <= sel_last;
              req_ack   <= grant;
              wdog      <= '0;
            end else begin
              if (!last_q) req_err <= grant;
              m_enable <= 1'b0;
              grant    <= '0;
              rr_ptr   <= next_ptr;
              gap_cnt  <= '0;
              state    <= RELEASE;
            end
          end else if (wdog == WD_LAST) begin
            req_err  <= grant;
            m_enable <= 1'b0;
            grant    <= '0;
            rr_ptr   <= next_ptr;
            gap_cnt  <= '0;
            state    <= RELEASE;
          end else begin
            wdog <= wdog + WD_W'(1);
          end
        end
        RELEASE: begin
          if (gap_cnt == GAP_LAST) state <= IDLE;
          else gap_cnt <= gap_cnt + GAP_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// tb/tb_i2c_bus_arbiter.sv - randomized transaction-level bench for i2c_bus_arbiter
module tb_i2c_bus_arbiter;
  import i2c_arb_pkg::*;

  localparam int N   = 3;
  localparam int TMO = 100;
  localparam int GAP = 32;

  logic           clk_32M = 1'b0;
  logic           rst_n   = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_last = '0;
  logic [8*N-1:0] req_reg_addr = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_ack;
  logic [N-1:0]   req_err;
  logic [N-1:0]   grant;
  logic           m_enable;
  logic [7:0]     m_reg_addr;
  logic [7:0]     m_data_in;
  logic           m_done = 1'b0;

  always #5 clk_32M = ~clk_32M;

  i2c_bus_arbiter #(
    .N_REQ      (N),
    .TIMEOUT    (TMO),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk_32M      (clk_32M),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_last     (req_last),
    .req_reg_addr (req_reg_addr),
    .req_data     (req_data),
    .req_ack      (req_ack),
    .req_err      (req_err),
    .grant        (grant),
    .m_enable     (m_enable),
    .m_reg_addr   (m_reg_addr),
    .m_data_in    (m_data_in),
    .m_done       (m_done)
  );

  int   total = 0;
  int   bad   = 0;
  int   exp_ptr = 0;
  bit   settled = 1'b1;
  bit   noise_en = 1'b0;
  int   owner = 0;
  logic [7:0] r_addr [N];
  logic [7:0] r_data [N][4];
  int         r_len  [N];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge; non-owners get random garbage that must be ignored.
  task automatic tick();
    @(negedge clk_32M);
    if (noise_en) begin
      for (int i = 0; i < N; i++) begin
        if (i != owner) begin
          req_valid[i]          = 1'($urandom);
          req_last[i]           = 1'($urandom);
          req_data[8*i +: 8]    = 8'($urandom);
          req_reg_addr[8*i +: 8] = 8'($urandom);
        end
      end
    end
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input int len,
                         input logic [7:0] d0, input logic [7:0] d1,
                         input logic [7:0] d2, input logic [7:0] d3);
    r_addr[i]    = a;
    r_len[i]     = len;
    r_data[i][0] = d0;
    r_data[i][1] = d1;
    r_data[i][2] = d2;
    r_data[i][3] = d3;
  endtask

  task automatic stage(input int w, input int k, input bit starve);
    if (starve || k >= r_len[w]) begin
      req_valid[w] = 1'b0;
    end else begin
      req_valid[w]       = 1'b1;
      req_data[8*w +: 8] = r_data[w][k];
      req_last[w]        = (k == r_len[w] - 1);
    end
  endtask

  // mode: 0 normal, 1 underrun after first byte, 2 no m_done (timeout),
  // 3 first m_done arrives in the last cycle before the watchdog would fire
  task automatic do_round(input logic [N-1:0] mask, input int mode, input int idle_w);
    int w, cyc, k, d, cnt, exp_sp;
    logic [N-1:0] oh;
    bit fin;
    req_valid = '0;
    m_done    = 1'b0;
    repeat (idle_w) tick();
    w = -1;
    for (int j = 0; j < N; j++) begin
      if (w < 0 && mask[(exp_ptr + j) % N]) w = (exp_ptr + j) % N;
    end
    oh = '0;
    oh[w] = 1'b1;
    for (int i = 0; i < N; i++) begin
      req_valid[i]           = mask[i];
      req_last[i]            = (r_len[i] == 1);
      req_reg_addr[8*i +: 8] = r_addr[i];
      req_data[8*i +: 8]     = r_data[i][0];
    end
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!m_enable && cyc < 400);
    exp_sp = settled ? idle_w + 1 : ((idle_w + 1 > GAP + 1) ? idle_w + 1 : GAP + 1);
    chk("spacing", 32'(idle_w + cyc), 32'(exp_sp));
    chk("grant", 32'(grant), 32'(oh));
    chk("first_ack", 32'(req_ack), 32'(oh));
    chk("first_addr", 32'(m_reg_addr), 32'(r_addr[w]));
    chk("first_data", 32'(m_data_in), 32'(r_data[w][0]));
    chk("first_err", 32'(req_err), 32'd0);
    owner    = w;
    noise_en = 1'b1;
    k        = 1;
    stage(w, k, mode == 1);
    if (mode == 2) begin
      cnt = 0;
      do begin
        tick();
        cnt++;
      end while (req_err == '0 && cnt < TMO + 20);
      chk("tmo_lat", 32'(cnt), 32'(TMO));
      chk("tmo_err", 32'(req_err), 32'(oh));
      chk("tmo_en", 32'(m_enable), 32'd0);
      chk("tmo_grant", 32'(grant), 32'd0);
    end else begin
      fin = 1'b0;
      while (!fin) begin
        d = (mode == 3 && k == 1) ? TMO - 1 : int'($urandom_range(0, 4));
        repeat (d) tick();
        chk("en_hold", 32'(m_enable), 32'd1);
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
        if (mode == 1) begin
          chk("urun_err", 32'(req_err), 32'(oh));
          chk("urun_en", 32'(m_enable), 32'd0);
          fin = 1'b1;
        end else if (k >= r_len[w]) begin
          chk("end_en", 32'(m_enable), 32'd0);
          chk("end_grant", 32'(grant), 32'd0);
          chk("end_err", 32'(req_err), 32'd0);
          fin = 1'b1;
        end else begin
          chk("nxt_ack", 32'(req_ack), 32'(oh));
          chk("nxt_data", 32'(m_data_in), 32'(r_data[w][k]));
          chk("nxt_addr", 32'(m_reg_addr), 32'(r_addr[w]));
          chk("nxt_en", 32'(m_enable), 32'd1);
          k++;
          stage(w, k, 1'b0);
        end
      end
    end
    noise_en  = 1'b0;
    req_valid = '0;
    exp_ptr   = (w + 1) % N;
    settled   = 1'b0;
  endtask

  task automatic reset_mid_burst();
    int cyc;
    set_req(0, OLED_CTRL_DAT, 4, 8'h11, 8'h22, 8'h33, 8'h44);
    req_valid    = '0;
    req_valid[0] = 1'b1;
    req_last[0]  = 1'b0;
    req_reg_addr[7:0] = r_addr[0];
    req_data[7:0]     = r_data[0][0];
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!m_enable && cyc < 400);
    chk("rst_pre_en", 32'(m_enable), 32'd1);
    req_data[7:0] = r_data[0][1];
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_en", 32'(m_enable), 32'd0);
    chk("rst_addr", 32'(m_reg_addr), 32'd0);
    chk("rst_data", 32'(m_data_in), 32'd0);
    chk("rst_err", 32'(req_err), 32'd0);
    req_valid = '0;
    tick();
    tick();
    rst_n   = 1'b1;
    exp_ptr = 0;
    settled = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [N-1:0] mask;
    int mode, sel, idle;
    repeat (3) @(negedge clk_32M);
    chk("reset_grant", 32'(grant), 32'd0);
    chk("reset_en", 32'(m_enable), 32'd0);
    chk("reset_addr", 32'(m_reg_addr), 32'd0);
    chk("reset_data", 32'(m_data_in), 32'd0);
    chk("reset_ack", 32'(req_ack), 32'd0);
    chk("reset_err", 32'(req_err), 32'd0);
    rst_n = 1'b1;
    tick();

    set_req(0, OLED_CTRL_CMD, 1, 8'hAE, 8'h00, 8'h00, 8'h00);
    do_round(3'b001, 0, 0);
    set_req(1, OLED_CTRL_DAT, 3, 8'hFF, 8'hFF, 8'hFF, 8'h00);
    do_round(3'b010, 0, 0);
    set_req(0, OLED_CTRL_CMD, 2, 8'hA1, 8'hC8, 8'h00, 8'h00);
    set_req(1, OLED_CTRL_DAT, 1, 8'h5A, 8'h00, 8'h00, 8'h00);
    do_round(3'b011, 0, 0);
    do_round(3'b011, 0, 3);
    do_round(3'b011, 0, 40);
    set_req(0, OLED_CTRL_DAT, 2, 8'h12, 8'h34, 8'h00, 8'h00);
    do_round(3'b001, 1, 0);
    do_round(3'b001, 2, 5);
    set_req(1, OLED_CTRL_CMD, 2, 8'h81, 8'h7F, 8'h00, 8'h00);
    do_round(3'b010, 3, 0);
    reset_mid_burst();
    do_round(3'b011, 0, 0);

    for (int r = 0; r < 40; r++) begin
      mask = 3'($urandom_range(1, 7));
      sel  = int'($urandom_range(0, 9));
      mode = (sel < 6) ? 0 : (sel < 8) ? 1 : (sel == 8) ? 2 : 3;
      for (int i = 0; i < N; i++) begin
        set_req(i, ($urandom_range(0, 1) != 0) ? OLED_CTRL_DAT : OLED_CTRL_CMD,
                int'($urandom_range((mode == 1) ? 2 : 1, 4)),
                8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      end
      idle = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 40));
      do_round(mask, mode, idle);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_bus_arbiter.md
# i2c_bus_arbiter

Shares the single `i2c_master` byte engine between `N_REQ` requesters: the OLED controller, the sensor poller and future peripherals. The arbiter grants the bus per transaction, not per byte, using round-robin. It streams the owner's bytes to the master as a burst and enforces a per-byte watchdog. After every transaction it inserts a bus-free gap before the next grant.

## Interface
Parameters:
- `N_REQ`, 2: number of requesters, range 2..8.
- `TIMEOUT`, 320_000: maximum cycles allowed from byte launch to `m_done` (10 ms at 32 MHz).
- `GAP_CYCLES`, 32: idle cycles with `m_enable` low after each transaction.

Ports (`rst_n` is asynchronous, active-low; clock is `clk_32M`):
- `clk_32M` in, 1: system clock.
- `rst_n` in, 1: asynchronous active-low reset.
- `req_valid` in, N_REQ: requester i has a byte presented.
- `req_last` in, N_REQ: presented byte is the final byte of the transaction.
- `req_reg_addr` in, 8*N_REQ: control byte (0x00 = command, 0x40 = data). It is sampled only on the first byte of a transaction.
- `req_data` in, 8*N_REQ: payload byte; slice i belongs to requester i.
- `req_ack` out, N_REQ: 1-cycle pulse when requester i's byte is latched. The requester may present its next byte in the following cycle.
- `req_err` out, N_REQ: 1-cycle pulse when requester i's transaction is aborted by timeout or underrun.
- `grant` out, N_REQ: one-hot current owner, or all zero.
- `m_enable` out, 1: drives master `enable`; it is high for the whole burst.
- `m_reg_addr` out, 8: drives master `reg_addr`.
- `m_data_in` out, 8: drives master `data_in`.
- `m_done` in, 1: 1-cycle pulse from the master when a byte completes.

## Operation
States: IDLE, XFER, RELEASE.

- **IDLE**
  - `m_enable` = 0 and `grant` = 0.
  - If any `req_valid` is high, pick the first set bit at or after `rr_ptr`, wrapping around.
  - In the same edge, register: `grant`, `m_reg_addr`, `m_data_in`, `last_q` (from `req_last`), `m_enable` = 1, and a `req_ack` pulse.
  - Go to XFER.
- **XFER**
  - The watchdog counter increments every cycle and clears on each byte latch.
  - On `m_done` with `last_q` = 1: go to RELEASE.
  - On `m_done` with `last_q` = 0 and the owner's `req_valid` = 1: latch the next `req_data` and `req_last`, pulse `req_ack`, and stay in XFER. `m_reg_addr` is unchanged.
  - On `m_done` with `last_q` = 0 and the owner's `req_valid` = 0 (underrun): pulse `req_err` and go to RELEASE.
  - When the watchdog reaches `TIMEOUT` with no `m_done`: pulse `req_err` and go to RELEASE.
- **RELEASE**
  - `m_enable` = 0 and `grant` = 0.
  - Set `rr_ptr` = owner + 1, modulo `N_REQ`.
  - The gap counter counts to `GAP_CYCLES` − 1, then the state returns to IDLE.

Boundary rules:
- `req_valid` is ignored in RELEASE.
- `m_done` is ignored in IDLE and RELEASE.
- If `m_done` and timeout occur in the same cycle, `m_done` wins.
- Non-owner `req_*` inputs never affect the outputs.
- The watchdog width is $clog2(TIMEOUT+1). The gap counter width is $clog2(GAP_CYCLES+1).

## Timing
- Reset values: `grant` = 0, `m_enable` = 0, `m_reg_addr` = 0x00, `m_data_in` = 0x00, `req_ack` = 0, `req_err` = 0, `rr_ptr` = 0, state = IDLE.
- Reset asserted mid-transaction drops `m_enable` immediately, with no `req_err` pulse.
- Latency from `req_valid` sampled in IDLE to `m_enable` = 1 and `req_ack` visible: 1 cycle.
- Latency from `m_done` to the next byte on `m_data_in`: 1 cycle (registered).
- Latency from `m_done` of the last byte to `m_enable` = 0: 1 cycle.
- Minimum spacing between transactions: `GAP_CYCLES` + 1 cycles from `m_enable` falling to the next `m_enable` rising.
- All outputs are registered.

## Structure
- Package `i2c_arb_pkg` holds:
  - the state enum {IDLE, XFER, RELEASE};
  - default constants `I2C_TIMEOUT_DEF` and `I2C_GAP_DEF`;
  - the constants `OLED_CTRL_CMD` = 0x00 and `OLED_CTRL_DAT` = 0x40.
- Sub-module `i2c_rr_pick`: a purely combinational round-robin picker. Inputs are `req_valid` and `rr_ptr`; outputs are the one-hot winner and `any`.

## Test plan
- **Single-byte transaction:** req0 presents 0x00/0xAE with `last` = 1. Expect `grant` = 01, `m_enable` = 1 and `m_data_in` = 0xAE one cycle later. After `m_done`, expect `m_enable` = 0 one cycle later and no grant for 32 cycles.
- **Burst:** req1 sends 0x40 followed by 3 bytes 0xFF, with `last` on the third. Expect 3 `req_ack` pulses, `m_reg_addr` held at 0x40, and `m_enable` continuously high until the third `m_done`.
- **Round-robin:** req0 and req1 both request from reset. Expect req0 to win first, then req1, then req0.
- **Underrun:** in a 2-byte burst, hold req0 `req_valid` low at the first `m_done`. Expect a `req_err`[0] pulse and `m_enable` = 0 one cycle later.
- **Timeout (TIMEOUT = 100):** `m_done` never arrives. Expect `req_err` pulsed 100 cycles after the byte latch and the grant released.
- **Reset mid-burst:** assert `rst_n` low during XFER. Expect all outputs 0 immediately; after reset is released, a new request is granted normally.
